// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encoding, opcode classes and the
// control-word layout used by the sequencer, its decoder and the top level.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } t_state_e;

  typedef enum logic [2:0] {
    OPC_NOP,
    OPC_LDA,
    OPC_ADD,
    OPC_SUB,
    OPC_OUT,
    OPC_HLT
  } op_class_e;

  localparam int unsigned CW_WIDTH    = 12;
  localparam int unsigned CW_PC_INC   = 11;
  localparam int unsigned CW_PC_OUT   = 10;
  localparam int unsigned CW_MAR_LOAD = 9;
  localparam int unsigned CW_RAM_OUT  = 8;
  localparam int unsigned CW_IR_LOAD  = 7;
  localparam int unsigned CW_IR_OUT   = 6;
  localparam int unsigned CW_A_LOAD   = 5;
  localparam int unsigned CW_A_OUT    = 4;
  localparam int unsigned CW_ALU_OUT  = 3;
  localparam int unsigned CW_ALU_SUB  = 2;
  localparam int unsigned CW_B_LOAD   = 1;
  localparam int unsigned CW_OUT_LOAD = 0;

  // Field order mirrors the CW_* bit indices above.
  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic mar_load;
    logic ram_out;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic alu_out;
    logic alu_sub;
    logic b_load;
    logic out_load;
  } ctrl_word_t;

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Control-sequencer signal bundle: clock qualifier and opcode in, T-state,
// control lines and halt status out.
interface sap1_control_sequencer_if #(
  parameter int unsigned OPCODE_WIDTH = 4
);
  logic                    mclk_en;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic [2:0]              o_t_state;
  logic                    o_pc_inc;
  logic                    o_pc_out;
  logic                    o_mar_load;
  logic                    o_ram_out;
  logic                    o_ir_load;
  logic                    o_ir_out;
  logic                    o_a_load;
  logic                    o_a_out;
  logic                    o_alu_out;
  logic                    o_alu_sub;
  logic                    o_b_load;
  logic                    o_out_load;
  logic                    o_halted;

  modport master (
    output mclk_en, i_opcode,
    input  o_t_state, o_pc_inc, o_pc_out, o_mar_load, o_ram_out, o_ir_load,
           o_ir_out, o_a_load, o_a_out, o_alu_out, o_alu_sub, o_b_load,
           o_out_load, o_halted
  );

  modport slave (
    input  mclk_en, i_opcode,
    output o_t_state, o_pc_inc, o_pc_out, o_mar_load, o_ram_out, o_ir_load,
           o_ir_out, o_a_load, o_a_out, o_alu_out, o_alu_sub, o_b_load,
           o_out_load, o_halted
  );
endinterface

// File: rtl/sap1_microcode_decode.sv
// Purely combinational microcode ROM: (T-state, opcode) -> control word, plus
// the opcode class the sequencer uses for its early-end decisions.
module sap1_microcode_decode
  import sap1_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  t_state_e                t_state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output op_class_e               op_class,
  output ctrl_word_t              cw
);

  logic [CW_WIDTH-1:0] bits;

  always_comb begin
    op_class = OPC_NOP;
    if (opcode == OPCODE_WIDTH'(OP_LDA))      op_class = OPC_LDA;
    else if (opcode == OPCODE_WIDTH'(OP_ADD)) op_class = OPC_ADD;
    else if (opcode == OPCODE_WIDTH'(OP_SUB)) op_class = OPC_SUB;
    else if (opcode == OPCODE_WIDTH'(OP_OUT)) op_class = OPC_OUT;
    else if (opcode == OPCODE_WIDTH'(OP_HLT)) op_class = OPC_HLT;
  end

  always_comb begin
    bits = '0;
    case (t_state)
      T1: begin
        bits[CW_PC_OUT]   = 1'b1;
        bits[CW_MAR_LOAD] = 1'b1;
      end
      T2: bits[CW_PC_INC] = 1'b1;
      T3: begin
        bits[CW_RAM_OUT] = 1'b1;
        bits[CW_IR_LOAD] = 1'b1;
      end
      T4: begin
        case (op_class)
          OPC_LDA, OPC_ADD, OPC_SUB: begin
            bits[CW_IR_OUT]   = 1'b1;
            bits[CW_MAR_LOAD] = 1'b1;
          end
          OPC_OUT: begin
            bits[CW_A_OUT]    = 1'b1;
            bits[CW_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (op_class)
          OPC_LDA: begin
            bits[CW_RAM_OUT] = 1'b1;
            bits[CW_A_LOAD]  = 1'b1;
          end
          OPC_ADD: begin
            bits[CW_RAM_OUT] = 1'b1;
            bits[CW_B_LOAD]  = 1'b1;
          end
          // Subtract is selected a step early so the ALU settles before T6.
          OPC_SUB: begin
            bits[CW_RAM_OUT] = 1'b1;
            bits[CW_B_LOAD]  = 1'b1;
            bits[CW_ALU_SUB] = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (op_class)
          OPC_ADD: begin
            bits[CW_ALU_OUT] = 1'b1;
            bits[CW_A_LOAD]  = 1'b1;
          end
          OPC_SUB: begin
            bits[CW_ALU_OUT] = 1'b1;
            bits[CW_A_LOAD]  = 1'b1;
            bits[CW_ALU_SUB] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign cw = ctrl_word_t'(bits);

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: six-step T-state ring with halt flop and optional
// early return to T1; control lines are decoded from the current step.
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter bit          EARLY_END    = 1'b1
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  sap1_control_sequencer_if.slave  bus
);

  t_state_e   t_state;
  t_state_e   t_next;
  logic       halted;
  op_class_e  op_class;
  ctrl_word_t cw_dec;
  ctrl_word_t cw_out;

  sap1_microcode_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_decode (
    .t_state  (t_state),
    .opcode   (bus.i_opcode),
    .op_class (op_class),
    .cw       (cw_dec)
  );

  // The NOP skip is resolved at T4, not T3: at T3 the IR still holds the
  // previous instruction, so the new opcode is only trustworthy from T4 on.
  always_comb begin
    t_next = T1;
    case (t_state)
      T1: t_next = T2;
      T2: t_next = T3;
      T3: t_next = T4;
      T4: t_next = (EARLY_END && (op_class == OPC_OUT || op_class == OPC_NOP))
                   ? T1 : T5;
      T5: t_next = (EARLY_END && op_class == OPC_LDA) ? T1 : T6;
      T6: t_next = T1;
      default: t_next = T1;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else if (bus.mclk_en && !halted) begin
      if (t_state == T4 && op_class == OPC_HLT) begin
        halted <= 1'b1;
      end else begin
        t_state <= t_next;
      end
    end
  end

  assign cw_out = (halted || !rst_n) ? '0 : cw_dec;

  assign bus.o_t_state  = t_state;
  assign bus.o_halted   = halted;
  assign bus.o_pc_inc   = cw_out.pc_inc;
  assign bus.o_pc_out   = cw_out.pc_out;
  assign bus.o_mar_load = cw_out.mar_load;
  assign bus.o_ram_out  = cw_out.ram_out;
  assign bus.o_ir_load  = cw_out.ir_load;
  assign bus.o_ir_out   = cw_out.ir_out;
  assign bus.o_a_load   = cw_out.a_load;
  assign bus.o_a_out    = cw_out.a_out;
  assign bus.o_alu_out  = cw_out.alu_out;
  assign bus.o_alu_sub  = cw_out.alu_sub;
  assign bus.o_b_load   = cw_out.b_load;
  assign bus.o_out_load = cw_out.out_load;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Scoreboard bench for sap1_control_sequencer: one DUT with early end, one
// without, driven in lockstep and checked against an instruction-level model.
module tb_sap1_control_sequencer;

  localparam logic [11:0] PC_INC   = 12'h800;
  localparam logic [11:0] PC_OUT   = 12'h400;
  localparam logic [11:0] MAR_LOAD = 12'h200;
  localparam logic [11:0] RAM_OUT  = 12'h100;
  localparam logic [11:0] IR_LOAD  = 12'h080;
  localparam logic [11:0] IR_OUT   = 12'h040;
  localparam logic [11:0] A_LOAD   = 12'h020;
  localparam logic [11:0] A_OUT    = 12'h010;
  localparam logic [11:0] ALU_OUT  = 12'h008;
  localparam logic [11:0] ALU_SUB  = 12'h004;
  localparam logic [11:0] B_LOAD   = 12'h002;
  localparam logic [11:0] OUT_LOAD = 12'h001;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;

  sap1_control_sequencer_if #(.OPCODE_WIDTH(4)) bus1 ();
  sap1_control_sequencer_if #(.OPCODE_WIDTH(4)) bus0 ();

  sap1_control_sequencer #(.OPCODE_WIDTH(4), .EARLY_END(1'b1)) dut_e1 (
    .mclk(mclk), .rst_n(rst_n), .bus(bus1));
  sap1_control_sequencer #(.OPCODE_WIDTH(4), .EARLY_END(1'b0)) dut_e0 (
    .mclk(mclk), .rst_n(rst_n), .bus(bus0));

  always #5 mclk = ~mclk;

  // Index 0 observes the early-end DUT, index 1 the full-length DUT.
  logic [11:0] cw_act [2];
  logic [2:0]  t_act  [2];
  logic        h_act  [2];
  logic [4:0]  drv_act[2];

  assign cw_act[0] = {bus1.o_pc_inc, bus1.o_pc_out, bus1.o_mar_load, bus1.o_ram_out,
                      bus1.o_ir_load, bus1.o_ir_out, bus1.o_a_load, bus1.o_a_out,
                      bus1.o_alu_out, bus1.o_alu_sub, bus1.o_b_load, bus1.o_out_load};
  assign cw_act[1] = {bus0.o_pc_inc, bus0.o_pc_out, bus0.o_mar_load, bus0.o_ram_out,
                      bus0.o_ir_load, bus0.o_ir_out, bus0.o_a_load, bus0.o_a_out,
                      bus0.o_alu_out, bus0.o_alu_sub, bus0.o_b_load, bus0.o_out_load};
  assign t_act[0]   = bus1.o_t_state;
  assign t_act[1]   = bus0.o_t_state;
  assign h_act[0]   = bus1.o_halted;
  assign h_act[1]   = bus0.o_halted;
  assign drv_act[0] = {bus1.o_pc_out, bus1.o_ir_out, bus1.o_ram_out, bus1.o_a_out, bus1.o_alu_out};
  assign drv_act[1] = {bus0.o_pc_out, bus0.o_ir_out, bus0.o_ram_out, bus0.o_a_out, bus0.o_alu_out};

  typedef struct {
    string       tag;
    int          t0, t1;
    logic [11:0] cw0, cw1;
    bit          h0, h1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int         m_step  [2];
  bit         m_halted[2];
  logic       cur_rst = 1'b0;
  logic       cur_en  = 1'b0;
  logic [3:0] cur_op  = 4'h0;

  function automatic void check(input string tag, input string what, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, got, exp);
    end
  endfunction

  // Number of steps an instruction occupies before the ring wraps to T1.
  function automatic int instr_len(input int k, input logic [3:0] op);
    if (k == 1) return 6;
    case (op)
      4'h0:       return 5;
      4'h1, 4'h2: return 6;
      4'hE:       return 4;
      4'hF:       return 6;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [11:0] exp_cw(input int k);
    int  s;
    bit  is_sub;
    s = m_step[k];
    if (!cur_rst || m_halted[k]) return '0;
    if (s == 1) return PC_OUT | MAR_LOAD;
    if (s == 2) return PC_INC;
    if (s == 3) return RAM_OUT | IR_LOAD;
    is_sub = (cur_op == 4'h2);
    case (cur_op)
      4'h0: begin
        if (s == 4) return IR_OUT | MAR_LOAD;
        if (s == 5) return RAM_OUT | A_LOAD;
        return '0;
      end
      4'h1, 4'h2: begin
        if (s == 4) return IR_OUT | MAR_LOAD;
        if (s == 5) return RAM_OUT | B_LOAD | (is_sub ? ALU_SUB : 12'h000);
        return ALU_OUT | A_LOAD | (is_sub ? ALU_SUB : 12'h000);
      end
      4'hE:    return (s == 4) ? (A_OUT | OUT_LOAD) : 12'h000;
      default: return '0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_step[k]   = 1;
      m_halted[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!cur_rst) begin
        m_step[k]   = 1;
        m_halted[k] = 1'b0;
      end else if (cur_en && !m_halted[k]) begin
        if (m_step[k] == 4 && cur_op == 4'hF) m_halted[k] = 1'b1;
        else if (m_step[k] == instr_len(k, cur_op) || m_step[k] == 6) m_step[k] = 1;
        else m_step[k] = m_step[k] + 1;
      end
    end
  endfunction

  function automatic void push_expect(input string tag);
    exp_t e;
    e.tag = tag;
    e.t0  = m_step[0];   e.t1  = m_step[1];
    e.h0  = m_halted[0]; e.h1  = m_halted[1];
    e.cw0 = exp_cw(0);   e.cw1 = exp_cw(1);
    q.push_back(e);
  endfunction

  task automatic tick(input logic rst, input logic en, input logic [3:0] op, input string tag);
    @(posedge mclk);
    #1;
    model_edge();
    cur_rst = rst; cur_en = en; cur_op = op;
    rst_n = rst;
    bus1.mclk_en = en; bus1.i_opcode = op;
    bus0.mclk_en = en; bus0.i_opcode = op;
    if (!rst) model_reset();
    push_expect(tag);
  endtask

  // Edge advances as normal, then reset is asserted well before the next edge.
  task automatic tick_mid_reset(input string tag);
    @(posedge mclk);
    #1;
    model_edge();
    check(tag, "pre_reset_t_state", int'(t_act[0]), m_step[0]);
    #2;
    rst_n   = 1'b0;
    cur_rst = 1'b0;
    model_reset();
    push_expect(tag);
  endtask

  task automatic reset_seq(input logic [3:0] op);
    tick(1'b0, 1'b0, op, "reset");
    tick(1'b0, 1'b0, op, "reset");
    tick(1'b1, 1'b0, op, "release");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge mclk);
      for (int k = 0; k < 2; k++)
        check("bus", "drivers_gt1", ($countones(drv_act[k]) > 1) ? 1 : 0, 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, "e1_t_state", int'(t_act[0]), e.t0);
        check(e.tag, "e1_ctrl",    int'(cw_act[0]), int'(e.cw0));
        check(e.tag, "e1_halted",  int'(h_act[0]), int'(e.h0));
        check(e.tag, "e0_t_state", int'(t_act[1]), e.t1);
        check(e.tag, "e0_ctrl",    int'(cw_act[1]), int'(e.cw1));
        check(e.tag, "e0_halted",  int'(h_act[1]), int'(e.h1));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int         hcnt;
    logic       en;
    logic [3:0] op;
    bus1.mclk_en = 1'b0; bus1.i_opcode = 4'h0;
    bus0.mclk_en = 1'b0; bus0.i_opcode = 4'h0;
    model_reset();

    reset_seq(4'h0);
    repeat (12) tick(1'b1, 1'b1, 4'h0, "lda");

    reset_seq(4'h1);
    for (int i = 0; i < 40; i++) tick(1'b1, (i % 3) == 2, 4'h1, "add_en3");

    reset_seq(4'h2);
    repeat (14) tick(1'b1, 1'b1, 4'h2, "sub");

    reset_seq(4'hF);
    repeat (30) tick(1'b1, 1'b1, 4'hF, "hlt");

    reset_seq(4'hE);
    repeat (12) tick(1'b1, 1'b1, 4'hE, "out");

    reset_seq(4'h1);
    repeat (4) tick(1'b1, 1'b1, 4'h1, "add_pre");
    tick_mid_reset("add_mid_reset");
    tick(1'b0, 1'b0, 4'h1, "mid_hold");
    tick(1'b1, 1'b1, 4'h1, "mid_release");
    repeat (8) tick(1'b1, 1'b1, 4'h1, "add_after");

    reset_seq(4'h0);
    hcnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_halted[0]) hcnt++;
      if (hcnt > 4) begin
        hcnt = 0;
        reset_seq(4'($urandom_range(0, 15)));
      end else begin
        en = ($urandom_range(0, 3) != 0);
        op = cur_op;
        // A new opcode appears only after the IR-load edge of the early-end ring.
        if (cur_rst && cur_en && !m_halted[0] && m_step[0] == 3)
          op = 4'($urandom_range(0, 15));
        tick(1'b1, en, op, "rand");
      end
    end

    repeat (3) @(negedge mclk);
    #1;
    check("end", "queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
